collision_manager: RTL

Parametrised per-pixel collision arbiter with frame-level event gating and player-life tracking. Sits between the object drawers (player, aliens, rockets, borders) and the game-object movers. Converts raw drawing-request overlaps into single-cycle, once-per-frame event pulses. Owns the lives / invulnerability / game-over state machine.

---
 rtl/collision_pkg.sv | 22 ++
 rtl/collision_manager_if.sv | 47 ++++
 rtl/frame_event_gate.sv | 36 +++
 rtl/collision_manager.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared game-state type, default parameters and helpers for the collision manager.
package collision_pkg;

  typedef enum logic [1:0] {PLAY, INVULN, OVER} game_state_t;

  localparam int unsigned DefPRockets     = 2;
  localparam int unsigned DefARockets     = 3;
  localparam int unsigned DefLives        = 3;
  localparam int unsigned DefInvulnFrames = 60;
  localparam int          DefBorderY      = 479;
  localparam int unsigned DefScoreW       = 12;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/collision_manager_if.sv
// Drawer-side inputs and mover-side event outputs of the collision manager.
// The slave modport is the manager itself; master is whoever drives the pixel stream.
interface collision_manager_if
  import collision_pkg::*;
#(
  parameter int unsigned P_ROCKETS = DefPRockets,
  parameter int unsigned A_ROCKETS = DefARockets,
  parameter int unsigned LIVES     = DefLives,
  parameter int unsigned SCORE_W   = DefScoreW
) ();

  localparam int unsigned LivesW = $clog2(LIVES + 1);

  logic                  startOfFrame;
  logic signed [10:0]    pixelX;
  logic signed [10:0]    pixelY;
  logic                  drawing_request_player;
  logic                  drawing_request_aliens;
  logic                  drawing_request_borders;
  logic [P_ROCKETS-1:0]  p_rockets_DR;
  logic [A_ROCKETS-1:0]  a_rockets_DR;

  logic [P_ROCKETS-1:0]  alienHit;
  logic [P_ROCKETS-1:0]  p_rocketsCollision;
  logic [A_ROCKETS-1:0]  a_rocketsCollision;
  logic                  playerHit;
  logic                  aliensReachedBorder;
  logic [LivesW-1:0]     livesLeft;
  logic                  invulnerable;
  logic                  gameOver;
  logic [SCORE_W-1:0]    score;

  modport master (
    output startOfFrame, pixelX, pixelY, drawing_request_player, drawing_request_aliens,
           drawing_request_borders, p_rockets_DR, a_rockets_DR,
    input  alienHit, p_rocketsCollision, a_rocketsCollision, playerHit, aliensReachedBorder,
           livesLeft, invulnerable, gameOver, score
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, drawing_request_player, drawing_request_aliens,
           drawing_request_borders, p_rockets_DR, a_rockets_DR,
    output alienHit, p_rocketsCollision, a_rocketsCollision, playerHit, aliensReachedBorder,
           livesLeft, invulnerable, gameOver, score
  );

endinterface

// File: rtl/frame_event_gate.sv
// Once-per-frame pulse gate: a request bit fires only while its mask bit is clear, and firing
// sets the mask. clear_i (start of frame) wipes the masks before this cycle's requests are judged.
module frame_event_gate #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] req_i,
  output logic [Width-1:0] fire_o,
  output logic [Width-1:0] pulse_o
);

  logic [Width-1:0] mask_q, mask_d, mask_eff;
  logic [Width-1:0] pulse_q;

  always_comb begin
    mask_eff = clear_i ? '0 : mask_q;
    fire_o   = req_i & ~mask_eff & {Width{en_i}};
    mask_d   = mask_eff | fire_o;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      pulse_q <= '0;
    end else begin
      mask_q  <= mask_d;
      pulse_q <= fire_o;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/collision_manager.sv
// Per-pixel collision arbiter with once-per-frame event pulses and the lives/invulnerability FSM.
// Define COLLISION_SCORE_EN to build the saturating alien-kill score counter; otherwise score is 0.
module collision_manager
  import collision_pkg::*;
#(
  parameter int unsigned P_ROCKETS     = DefPRockets,
  parameter int unsigned A_ROCKETS     = DefARockets,
  parameter int unsigned LIVES         = DefLives,
  parameter int unsigned INVULN_FRAMES = DefInvulnFrames,
  parameter int          BORDER_Y      = DefBorderY,
  parameter int unsigned SCORE_W       = DefScoreW
) (
  input logic                clk,
  input logic                reset,
  collision_manager_if.slave bus
);

  localparam int unsigned LivesW = $clog2(LIVES + 1);
  localparam int unsigned CntW   = $clog2(INVULN_FRAMES + 1);
  localparam logic signed [10:0] BorderY = 11'(BORDER_Y);

  logic                 any_a, rr_hit, player_raw, border_raw;
  logic [P_ROCKETS-1:0] kill_raw, p_coll_raw;
  logic [A_ROCKETS-1:0] a_coll_raw;

  always_comb begin
    any_a      = |bus.a_rockets_DR;
    rr_hit     = (|bus.p_rockets_DR) & any_a;
    kill_raw   = {P_ROCKETS{bus.drawing_request_aliens}} & bus.p_rockets_DR;
    p_coll_raw = kill_raw
               | ({P_ROCKETS{rr_hit | bus.drawing_request_borders}} & bus.p_rockets_DR);
    a_coll_raw = {A_ROCKETS{rr_hit | bus.drawing_request_borders | bus.drawing_request_player}}
               & bus.a_rockets_DR;
    player_raw = bus.drawing_request_player & (bus.drawing_request_aliens | any_a);
    border_raw = bus.drawing_request_aliens & ($signed(bus.pixelY) > BorderY);
  end

  game_state_t       state_q, state_d;
  logic [LivesW-1:0] lives_q, lives_d;
  logic [CntW-1:0]   frame_cnt_q, frame_cnt_d;

  logic                 gate_en, player_req;
  logic                 border_fire, player_fire;
  logic [P_ROCKETS-1:0] alien_fire, p_coll_fire;
  logic [A_ROCKETS-1:0] a_coll_fire;

  assign gate_en = (state_q != OVER);
  // Border reach outranks a same-cycle player hit, so the hit must not consume its mask.
  assign player_req = player_raw & (state_q == PLAY) & ~border_fire;

  frame_event_gate #(.Width(P_ROCKETS)) u_alien_gate (
    .clk     (clk),
    .reset   (reset),
    .clear_i (bus.startOfFrame),
    .en_i    (gate_en),
    .req_i   (kill_raw),
    .fire_o  (alien_fire),
    .pulse_o (bus.alienHit)
  );

  frame_event_gate #(.Width(P_ROCKETS)) u_p_coll_gate (
    .clk     (clk),
    .reset   (reset),
    .clear_i (bus.startOfFrame),
    .en_i    (gate_en),
    .req_i   (p_coll_raw),
    .fire_o  (p_coll_fire),
    .pulse_o (bus.p_rocketsCollision)
  );

  frame_event_gate #(.Width(A_ROCKETS)) u_a_coll_gate (
    .clk     (clk),
    .reset   (reset),
    .clear_i (bus.startOfFrame),
    .en_i    (gate_en),
    .req_i   (a_coll_raw),
    .fire_o  (a_coll_fire),
    .pulse_o (bus.a_rocketsCollision)
  );

  frame_event_gate #(.Width(1)) u_border_gate (
    .clk     (clk),
    .reset   (reset),
    .clear_i (bus.startOfFrame),
    .en_i    (gate_en),
    .req_i   (border_raw),
    .fire_o  (border_fire),
    .pulse_o (bus.aliensReachedBorder)
  );

  frame_event_gate #(.Width(1)) u_player_gate (
    .clk     (clk),
    .reset   (reset),
    .clear_i (bus.startOfFrame),
    .en_i    (gate_en),
    .req_i   (player_req),
    .fire_o  (player_fire),
    .pulse_o (bus.playerHit)
  );

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    if (border_fire) begin
      state_d = OVER;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (player_fire) begin
            if (lives_q <= LivesW'(1)) begin
              state_d = OVER;
              lives_d = '0;
            end else begin
              state_d     = INVULN;
              lives_d     = lives_q - LivesW'(1);
              frame_cnt_d = '0;
            end
          end
        end
        INVULN: begin
          if (bus.startOfFrame) begin
            if (frame_cnt_q == CntW'(INVULN_FRAMES - 1)) begin
              state_d     = PLAY;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + CntW'(1);
            end
          end
        end
        OVER: ;
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLAY;
      lives_q     <= LivesW'(LIVES);
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.livesLeft    = lives_q;
  assign bus.invulnerable = (state_q == INVULN);
  assign bus.gameOver     = (state_q == OVER);

`ifdef COLLISION_SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   score_sum;

  always_comb begin
    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(popcount(32'(alien_fire)));
    score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign bus.score = score_q;
`else
  logic unused_alien_fire;
  assign unused_alien_fire = ^alien_fire;
  assign bus.score = '0;
`endif

  logic unused_sig;
  assign unused_sig = ^{bus.pixelX, p_coll_fire, a_coll_fire};

endmodule
